// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the parametrised multi-cycle ALU.
//   opcode_e : 4-bit operation select (same encoding as the 16-bit ALU)
//   state_e  : control FSM states
//   mode_e   : iterative engine mode (multiply or divide)
//   iter_count(): iteration cycles needed by the engine for a given width
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd     = 4'd0,
    OpSub     = 4'd1,
    OpMult    = 4'd2,
    OpDiv     = 4'd3,
    OpAnd     = 4'd4,
    OpOr      = 4'd5,
    OpNand    = 4'd6,
    OpNor     = 4'd7,
    OpXor     = 4'd8,
    OpSl      = 4'd9,
    OpSr      = 4'd10,
    OpCsl     = 4'd11,
    OpCsr     = 4'd12,
    OpGreater = 4'd13,
    OpSmaller = 4'd14,
    OpEqual   = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StIter = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic {
    ModeMul = 1'b0,
    ModeDiv = 1'b1
  } mode_e;

  // Width the original ALU was built for; the iteration count equals the width.
  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultIters = DefaultWidth;

  // One product/quotient bit per cycle.
  function automatic int unsigned iter_count(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared iterative engine for unsigned shift-add multiply and
// restoring divide, one bit per cycle, WIDTH iterations after load.
// Ports:
//   clk, reset_a      clock, asynchronous active-low reset
//   load              capture mode and operands, restart the iteration count
//   mode              ModeMul or ModeDiv
//   dataa, datab      multiplicand/dividend and multiplier/divisor
//   result_hi         product high half or remainder
//   result_lo         product low half or quotient
//   finished          all iterations done; results stable until next load
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_a,
  input  logic             load,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             finished
);

  localparam int unsigned Iters = iter_count(WIDTH);
  localparam int unsigned CntW  = $clog2(Iters + 1);

  mode_e            mode_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  always_comb begin
    // Multiply: {hi, lo} holds partial product over the shifting multiplier.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    // True difference is below the divisor, so the modular W-bit subtract is exact.
    div_diff  = div_shift[WIDTH-1:0] - b_q;

    hi_d = hi_q;
    lo_d = lo_q;
    if (mode_q == ModeMul) begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  assign finished  = (cnt_q == CntW'(Iters));
  assign result_hi = hi_q;
  assign result_lo = lo_q;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      mode_q <= ModeMul;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= CntW'(Iters);  // idle until the first load
    end else if (load) begin
      mode_q <= mode;
      hi_q   <= '0;
      lo_q   <= dataa;
      b_q    <= datab;
      cnt_q  <= '0;
    end else if (!finished) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_param.sv
// alu_param: WIDTH-bit multi-cycle integer ALU with start/done handshake.
// Single-cycle ops complete one edge after issue; MULT/DIV run WIDTH
// iterations in alu_muldiv_iter. Result and flags hold until the next result.
// Ports:
//   clk, reset_a        clock, asynchronous active-low reset
//   start, opcode       issue request (sampled only when idle) and operation
//   dataa, datab        operands, latched on issue
//   out                 2*WIDTH registered result
//   carry_flag          ADD carry-out / SUB borrow
//   overflow_flag       two's-complement overflow on ADD/SUB
//   zero_flag           out == 0
//   div_zero_flag       DIV issued with datab == 0
//   busy, done          busy from issue until done falls; done is a 1-cycle pulse
// Build option: define ALU_REMAINDER_EN to return the DIV remainder in the
// upper half of out; otherwise the upper half is 0 for DIV.
module alu_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic [2*WIDTH-1:0] out,
  output logic               carry_flag,
  output logic               overflow_flag,
  output logic               zero_flag,
  output logic               div_zero_flag,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  opcode_e            op_q, op_in;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] out_q, res_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q;
  logic               dz_q, dz_d;

  logic               issue;
  logic               load;
  logic               res_en;
  logic               iter_op;

  logic [WIDTH-1:0]   eng_hi, eng_lo;
  logic               eng_finished;

  logic [WIDTH:0]     sum, diff;

  assign op_in   = opcode_e'(opcode);
  assign iter_op = (op_in == OpMult) || (op_in == OpDiv);

  // Control FSM
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    res_en  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          issue   = 1'b1;
          load    = iter_op;
          state_d = iter_op ? StIter : StExec;
        end
      end
      StExec: begin
        res_en  = 1'b1;
        state_d = StDone;
      end
      StIter: begin
        if (eng_finished) begin
          res_en  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset_a  (reset_a),
    .load     (load),
    .mode     ((op_in == OpDiv) ? ModeDiv : ModeMul),
    .dataa    (dataa),
    .datab    (datab),
    .result_hi(eng_hi),
    .result_lo(eng_lo),
    .finished (eng_finished)
  );

  // Single-cycle datapath and result mux
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    dz_d    = 1'b0;
    case (op_q)
      OpAdd: begin
        res_d   = {{(WIDTH-1){1'b0}}, sum};
        carry_d = sum[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        res_d   = {{(WIDTH-1){1'b0}}, diff};
        carry_d = diff[WIDTH];  // borrow
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpMult:    res_d = {eng_hi, eng_lo};
      OpDiv: begin
`ifdef ALU_REMAINDER_EN
        res_d = {eng_hi, eng_lo};
`else
        res_d = {{WIDTH{1'b0}}, eng_lo};
`endif
        dz_d  = (b_q == '0);
      end
      OpAnd:     res_d = {{WIDTH{1'b0}}, a_q & b_q};
      OpOr:      res_d = {{WIDTH{1'b0}}, a_q | b_q};
      OpNand:    res_d = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OpNor:     res_d = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OpXor:     res_d = {{WIDTH{1'b0}}, a_q ^ b_q};
      OpSl:      res_d = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
      OpSr:      res_d = {{WIDTH{1'b0}}, 1'b0, a_q[WIDTH-1:1]};
      OpCsl:     res_d = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OpCsr:     res_d = {{WIDTH{1'b0}}, a_q[0], a_q[WIDTH-1:1]};
      OpGreater: res_d = {{(2*WIDTH-1){1'b0}}, a_q > b_q};
      OpSmaller: res_d = {{(2*WIDTH-1){1'b0}}, a_q < b_q};
      OpEqual:   res_d = {{(2*WIDTH-1){1'b0}}, a_q == b_q};
      default:   res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        op_q <= op_in;
        a_q  <= dataa;
        b_q  <= datab;
      end
      if (res_en) begin
        out_q   <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        zero_q  <= (res_d == '0);
        dz_q    <= dz_d;
      end
    end
  end

  assign out           = out_q;
  assign carry_flag    = carry_q;
  assign overflow_flag = ovf_q;
  assign zero_flag     = zero_q;
  assign div_zero_flag = dz_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);

endmodule
